// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Timing constants, framebuffer types and line-base helper for
//                the VGA framebuffer arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_AV     = 640;
    localparam int V_AV     = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int WPL      = H_AV / 16;
    localparam int FB_WORDS = WPL * V_AV;
    localparam int AW       = 15;

    typedef logic [AW-1:0] fb_addr_t;
    typedef logic [15:0]   fb_word_t;

    // Start-of-line word address; WPL is 40, so row*40 = (row<<5)+(row<<3).
    function automatic fb_addr_t line_base(input logic [9:0] row);
        fb_addr_t r;
        r = fb_addr_t'(row);
        return (r << 5) + (r << 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fetch_sched
//  Description : Combinational display-fetch strobe and word address, issued
//                one group ahead of the beam and at the end of each line.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fetch_sched
    import vga_pkg::*;
(
    input  logic [9:0]    i_x,
    input  logic [9:0]    i_y,
    output logic          o_fetch_strobe,
    output logic [AW-1:0] o_fetch_addr
);

    logic [9:0] w_yn;

    always_comb begin
        w_yn           = (i_y == 10'(V_TOTAL - 1)) ? 10'd0 : i_y + 10'd1;
        o_fetch_strobe = 1'b0;
        o_fetch_addr   = '0;
        if (i_x[3:0] == 4'd12 && i_x < 10'(H_AV - 16) && i_y < 10'(V_AV)) begin
            // Four pixels before the current group ends, fetch the following group.
            o_fetch_strobe = 1'b1;
            o_fetch_addr   = line_base(i_y) + fb_addr_t'(i_x[9:4]) + fb_addr_t'(1);
        end else if (i_x == 10'(H_TOTAL - 4) && w_yn < 10'(V_AV)) begin
            o_fetch_strobe = 1'b1;
            o_fetch_addr   = line_base(w_yn);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : Shares a single-port 1-bpp framebuffer RAM between display
//                scan-out (absolute priority) and a host command port.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic          pix_clk,
    input  logic          reset,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          valid,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [15:0]   cmd_wdata,
    output logic          rsp_valid,
    output logic [15:0]   rsp_data,
    output logic          cmd_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    output logic          pix_out
);

    logic     w_fetch;
    fb_addr_t w_fetch_addr;
    logic     w_fetch_go;
    logic     w_accept;
    logic     w_in_range;
    logic     w_host_mem;

    logic     r_up;
    logic     r_fetch_pend;
    logic     r_rd_pend;
    logic     r_rd_drop;
    logic     r_err;
    fb_addr_t r_last_addr;
    fb_word_t r_last_wdata;
    fb_word_t r_next_word;
    fb_word_t r_shreg;
    logic     r_pix;

    vga_fetch_sched u_fetch_sched (
        .i_x            (x),
        .i_y            (y),
        .o_fetch_strobe (w_fetch),
        .o_fetch_addr   (w_fetch_addr)
    );

    // r_up is low during reset and the first cycle after release, muting the RAM port.
    always_comb begin
        w_in_range = cmd_addr < fb_addr_t'(FB_WORDS);
        w_fetch_go = r_up & w_fetch;
        cmd_ready  = r_up & ~w_fetch;
        w_accept   = cmd_valid & cmd_ready;
        w_host_mem = w_accept & w_in_range;
        mem_en     = w_fetch_go | w_host_mem;
        mem_we     = w_host_mem & cmd_we;
        mem_addr   = w_fetch_go ? w_fetch_addr : (w_host_mem ? cmd_addr : r_last_addr);
        mem_wdata  = mem_we ? cmd_wdata : r_last_wdata;
        rsp_valid  = r_rd_pend | r_rd_drop;
        rsp_data   = r_rd_pend ? mem_rdata : '0;
        cmd_err    = r_err;
        pix_out    = r_pix;
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            r_up         <= 1'b0;
            r_fetch_pend <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_drop    <= 1'b0;
            r_err        <= 1'b0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
            r_next_word  <= '0;
            r_shreg      <= '0;
            r_pix        <= 1'b0;
        end else begin
            r_up         <= 1'b1;
            r_fetch_pend <= w_fetch_go;
            r_rd_pend    <= w_host_mem & ~cmd_we;
            r_rd_drop    <= w_accept & ~w_in_range & ~cmd_we;
            r_err        <= w_accept & ~w_in_range;
            if (mem_en) begin
                r_last_addr <= mem_addr;
            end
            if (mem_we) begin
                r_last_wdata <= cmd_wdata;
            end
            if (r_fetch_pend) begin
                r_next_word <= mem_rdata;
            end
            // LSB-first: bit 0 leaves on the load cycle, the rest shift out behind it.
            if (valid && x[3:0] == 4'd0) begin
                r_shreg <= {1'b0, r_next_word[15:1]};
                r_pix   <= r_next_word[0];
            end else begin
                r_shreg <= {1'b0, r_shreg[15:1]};
                r_pix   <= valid & r_shreg[0];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port 1-bpp framebuffer RAM (16 pixels per word) between VGA scan-out and a host command port.
- Sits between the VGA timing driver (x, y, valid on pix_clk) and the colour outputs; the host loads digit bitmaps through it.
- Display fetches take absolute priority and are scheduled ahead of the beam. The host gets every remaining RAM cycle.

Parameters:
- H_AV, 640, active pixels per line (multiple of 16)
- V_AV, 480, active lines
- H_TOTAL, 800, pixel clocks per line (x counts 0..H_TOTAL-1)
- V_TOTAL, 525, lines per frame
- WPL, H_AV/16 = 40, words per line
- FB_WORDS, WPL*V_AV = 19200, framebuffer depth
- AW, 15, address width

Ports:
- pix_clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- x  in  10  horizontal pixel count from the timing driver
- y  in  10  line count from the timing driver
- valid  in  1  active-video flag from the timing driver
- cmd_valid  in  1  host command present
- cmd_ready  out  1  host command accepted this cycle
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  AW  word address
- cmd_wdata  in  16  write data
- rsp_valid  out  1  read response strobe
- rsp_data  out  16  read response data
- cmd_err  out  1  pulse: out-of-range command dropped
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data; 1-cycle latency after mem_en
- pix_out  out  1  pixel for the colour path

Behaviour:
- Reset (asynchronous, active-high) clears every register.
  - Outputs while reset is high and on the first cycle after release: cmd_ready=0, rsp_valid=0, cmd_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_out=0, rsp_data=0.
  - Reset mid-operation discards any pending fetch, buffered word and read response. No response is emitted after reset.
- Fetch strobe (combinational from x, y) asserts in two cases:
  - (a) x[3:0]==12 and x < H_AV-16 and y < V_AV: fetch line y, group x[9:4]+1, at address y*WPL + x[9:4] + 1.
  - (b) x == H_TOTAL-4: fetch group 0 of the next line yn, at address yn*WPL.
    - yn = y+1, or 0 when y == V_TOTAL-1.
    - Issue only if yn < V_AV.
- Address computation:
  - y*WPL is formed with shift-add: (y<<5)+(y<<3).
  - Result is truncated to AW bits.
- Fetch cycle:
  - mem_en=1, mem_we=0, mem_addr=fetch address.
  - The next cycle, mem_rdata is captured into next_word. A tag bit marks it as a display fetch.
- Host arbitration:
  - cmd_ready = ~fetch_strobe and not in reset-release cycle.
  - Accept = cmd_valid & cmd_ready. The host never waits more than one consecutive cycle.
  - Write accept: mem_en=1, mem_we=1, mem_addr=cmd_addr, mem_wdata=cmd_wdata.
  - Read accept: mem_en=1, mem_we=0. rsp_valid=1 one cycle later, with rsp_data=mem_rdata.
- Out-of-range command (cmd_addr >= FB_WORDS):
  - Accepted but dropped: mem_en=0.
  - cmd_err pulses one cycle after accept.
  - A dropped read still produces rsp_valid with rsp_data=0.
- Pixel shift register:
  - When valid and x[3:0]==0, shreg loads next_word. Otherwise it shifts right by one each cycle.
  - Pixel order is LSB first.
  - pix_out is registered, 1-cycle latency: the output for position x is bit (x mod 16) of that group's word.
  - pix_out=0 whenever valid was low.
- Host write to the word being displayed: the new data appears from the next fetch of that address onward. There is no tearing protection.
- Unused RAM cycles hold mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.

Decomposition:
- Package vga_pkg holds:
  - timing constants H_AV, V_AV, H_TOTAL, V_TOTAL, WPL, FB_WORDS, AW
  - typedef fb_addr_t (logic [AW-1:0])
  - typedef fb_word_t (logic [15:0])
- One sub-module, vga_fetch_sched: pure combinational fetch-strobe and fetch-address generation from x, y.
- Arbitration, response tracking and the shifter stay in the top.

Test Plan:
- Preload word 0=16'h00FF, word 1=16'hFFFF; sweep line 0.
  - Fetch of word 1 at x=12.
  - pix_out = 1 for x=0..7, 0 for x=8..15, 1 for x=16..31, each one cycle late.
- Line-wrap fetch:
  - x=796, y=10 → mem_addr=440, mem_we=0.
  - x=796, y=524 → mem_addr=0.
  - x=796, y=479 → no fetch, and cmd_ready stays 1.
- Conflict:
  - cmd_valid write addr 5, data 16'hA5A5 held at x=12 (fetch cycle) → cmd_ready=0.
  - Accepted at x=13, with mem_we=1, mem_addr=5.
- Read round-trip: write 16'h1234 to addr 100, then read addr 100 → rsp_valid one cycle after accept, rsp_data=16'h1234.
- Out of range:
  - Write addr 19200 → accepted, mem_en=0, cmd_err pulse.
  - Read addr 20000 → rsp_valid with rsp_data=0 and cmd_err.
- Assert reset mid-frame during a pending read response:
  - All outputs go 0 immediately.
  - No rsp_valid after release.
  - cmd_ready=0 for one cycle, then follows the fetch schedule.
